lcd_iram_sink: RTL
==================

Name: lcd_iram_sink

Overview:
- Downstream stage of the LCD controller. Captures every IRAM write (IRAM_valid/IRAM_A/IRAM_D) into a local 64x8 frame memory.
- Tracks which addresses have been written and counts completed controller commands via the done edge.
- On request, streams the full frame out over a valid/ready port, addresses 0..63, and produces a 16-bit checksum.
- Used as the result frame store and checker hook for the image-processing path.

Parameters:
- DEPTH, 64, number of pixels in the frame (8x8).
- ADDR_W, 6, pixel address width.
- DATA_W, 8, pixel width.
- SUM_W, 16, checksum width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset, synchronous, active-high.
- iram_valid  input  1  write strobe from LCD controller.
- iram_a  input  ADDR_W  write address.
- iram_d  input  DATA_W  write data.
- lcd_done  input  1  controller done level.
- dump_req  input  1  start frame read-out; sampled in IDLE only.
- out_ready  input  1  consumer ready.
- out_valid  output  1  read-out data valid.
- out_addr  output  ADDR_W  address of out_data.
- out_data  output  DATA_W  pixel value; 0 if address never written.
- dump_busy  output  1  high in LOAD/DUMP/FIN.
- dump_done  output  1  one-cycle pulse after last beat.
- checksum  output  SUM_W  sum of streamed bytes mod 2^16.
- frame_complete  output  1  all 64 addresses written since reset.
- wr_count  output  7  distinct addresses written, 0..64.
- done_count  output  8  lcd_done rising edges, saturating at 255.
- wr_drop  output  1  sticky: a write arrived during dump and was dropped.

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE; written-bitmap cleared.
- Memory array is not cleared. Unwritten bits force out_data to 0.
- Reset asserted mid-dump aborts the dump immediately; no dump_done pulse.

Write path:
- Active in IDLE only. When iram_valid=1, mem[iram_a] <= iram_d at the clock edge.
- If bitmap[iram_a] was 0: set it and increment wr_count.
- Rewriting an address updates data; wr_count is unchanged.
- frame_complete = (wr_count == 64), combinational from the register.
- X on iram_a/iram_d is don't-care while iram_valid=0.

Done counter:
- lcd_done is registered; each 0->1 transition increments done_count, saturating at 255.
- lcd_done held high counts once.

FSM IDLE -> LOAD -> DUMP -> FIN -> IDLE:
- IDLE:
  - dump_req=1 -> LOAD; clear checksum to 0; set pointer ptr=0.
  - An iram_valid write in the same cycle as dump_req is performed, and its data appears in the dump.
- LOAD: one cycle for synchronous memory read of mem[ptr]; -> DUMP with out_valid=1, out_addr=ptr, out_data=bitmap[ptr]?mem[ptr]:0.
- DUMP, on handshake (out_valid & out_ready):
  - checksum += out_data (mod 2^16).
  - If ptr==63 -> FIN, with out_valid=0.
  - Otherwise ptr+1; the next beat is presented the following cycle, with no bubble allowed. The read is prefetched so that back-to-back ready gives 64 beats in 64 consecutive cycles.
- DUMP, while out_valid & !out_ready: out_addr and out_data are held stable; no beat is skipped or repeated.
- FIN: dump_done=1 for exactly one cycle -> IDLE. checksum holds its final value until the next dump start.

Dump boundaries:
- dump_req while not in IDLE is ignored.
- iram_valid during LOAD/DUMP/FIN: write dropped, memory and bitmap unchanged, wr_drop set. wr_drop clears only on reset.
- Dump latency: dump_req cycle N -> first out_valid at cycle N+2. Minimum dump length is 66 cycles from request to dump_done pulse (out_ready tied 1).

Test Plan:
- Reset, write mem[a]=a+1 for a=0..63 with iram_valid one per cycle, then dump_req, out_ready=1. Required response:
  - wr_count=64 and frame_complete=1.
  - 64 beats, out_addr 0..63, out_data 1..64, consecutive cycles.
  - checksum=2080 (0x0820) and a single dump_done pulse.
- Write only a=9 with 0xFF, a=9 again with 0x10, and a=63 with 0x80; dump. Required response:
  - wr_count=2.
  - out_data is 0 at all addresses except addr 9=0x10 and addr 63=0x80.
  - checksum=0x0090.
- Full frame of 0xFF, dump with out_ready toggling 1,0,0,1 pattern. Required response:
  - out_addr/out_data stable during stalls.
  - Exactly 64 beats; checksum=16320 (0x3FC0).
- Start a dump, then assert iram_valid at a=0, d=0x55 at beat 10. Required response:
  - wr_drop=1 and mem[0] unchanged in a second dump.
  - Then assert reset at beat 20: out_valid=0, dump_busy=0, wr_count=0 next cycle, no dump_done.
- Drive lcd_done with the pattern 0,1,1,0,1,0, then 300 further pulses. Required response:
  - done_count=2 after the pattern.
  - Saturates at 255 after the further pulses.
- iram_valid(a=5,d=0x22) and dump_req in the same cycle. Required response:
  - The dump shows addr 5=0x22.
  - A dump_req asserted during DUMP is ignored; still exactly one dump_done.

Source files
------------

// File: rtl/lcd_iram_sink_if.sv
// Bus between the LCD controller and the IRAM frame sink: write strobe, done level,
// dump control and the valid/ready read-out stream with its status outputs.
interface lcd_iram_sink_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int SUM_W  = 16
);
   logic              iram_valid;
   logic [ADDR_W-1:0] iram_a;
   logic [DATA_W-1:0] iram_d;
   logic              lcd_done;
   logic              dump_req;
   logic              out_ready;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              dump_busy;
   logic              dump_done;
   logic [SUM_W-1:0]  checksum;
   logic              frame_complete;
   logic [6:0]        wr_count;
   logic [7:0]        done_count;
   logic              wr_drop;

   modport master (
      output iram_valid, iram_a, iram_d, lcd_done, dump_req, out_ready,
      input  out_valid, out_addr, out_data, dump_busy, dump_done, checksum,
             frame_complete, wr_count, done_count, wr_drop
   );

   modport slave (
      input  iram_valid, iram_a, iram_d, lcd_done, dump_req, out_ready,
      output out_valid, out_addr, out_data, dump_busy, dump_done, checksum,
             frame_complete, wr_count, done_count, wr_drop
   );
endinterface

// File: rtl/lcd_iram_sink.sv
// Frame store behind the LCD controller: captures IRAM writes into a 64x8 memory,
// counts done edges, and streams the frame out with a running checksum on request.
module lcd_iram_sink #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int SUM_W  = 16
) (
   input  logic           clk,
   input  logic           reset,
   lcd_iram_sink_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DUMP, FIN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [6:0]        FULL = 7'(DEPTH);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  bitmap;
   logic [ADDR_W-1:0] ptr;
   logic              lcd_done_q;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   assign wr_en = (state == IDLE) && bus.iram_valid;
   // LOAD fetches beat 0; in DUMP the next beat is fetched on every handshake so the stream never bubbles
   assign rd_addr = (state == DUMP) ? ptr + ADDR_W'(1) : ptr;
   assign rd_data = bitmap[rd_addr] ? mem[rd_addr] : '0;
   assign bus.frame_complete = (bus.wr_count == FULL);

   // Memory contents survive reset; the bitmap alone decides what reads back as valid
   always_ff @(posedge clk)
      if (wr_en && !reset) mem[bus.iram_a] <= bus.iram_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= '0;
         bitmap         <= '0;
         lcd_done_q     <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_addr   <= '0;
         bus.out_data   <= '0;
         bus.dump_busy  <= 1'b0;
         bus.dump_done  <= 1'b0;
         bus.checksum   <= '0;
         bus.wr_count   <= '0;
         bus.done_count <= '0;
         bus.wr_drop    <= 1'b0;
      end else begin
         lcd_done_q <= bus.lcd_done;
         if (bus.lcd_done && !lcd_done_q && bus.done_count != 8'hFF)
            bus.done_count <= bus.done_count + 8'd1;

         if (wr_en && !bitmap[bus.iram_a]) begin
            bitmap[bus.iram_a] <= 1'b1;
            bus.wr_count       <= bus.wr_count + 7'd1;
         end
         if (bus.iram_valid && state != IDLE) bus.wr_drop <= 1'b1;

         case (state)
            IDLE: if (bus.dump_req) begin
               state         <= LOAD;
               ptr           <= '0;
               bus.checksum  <= '0;
               bus.dump_busy <= 1'b1;
            end
            LOAD: begin
               state         <= DUMP;
               bus.out_valid <= 1'b1;
               bus.out_addr  <= ptr;
               bus.out_data  <= rd_data;
            end
            DUMP: if (bus.out_ready) begin
               bus.checksum <= bus.checksum + SUM_W'(bus.out_data);
               if (ptr == LAST) begin
                  state         <= FIN;
                  bus.out_valid <= 1'b0;
                  bus.dump_done <= 1'b1;
               end else begin
                  ptr          <= rd_addr;
                  bus.out_addr <= rd_addr;
                  bus.out_data <= rd_data;
               end
            end
            FIN: begin
               state         <= IDLE;
               bus.dump_done <= 1'b0;
               bus.dump_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
